// File: rtl/ysyx_22041071_pc_gen.sv
// ----------------------------------------------------------------------------
// ysyx_22041071_pc_gen
//   PC generation stage at the head of the pipeline. It holds the fetch PC and
//   drives it to IF with a valid1/ready1 handshake. The PC advances by
//   INST_BYTES on each accepted request, takes redirects from later stages,
//   and stops for good on a halt request. Only reset leaves HALT.
//
// Ports
//   clk             in   1       pipeline clock
//   reset           in   1       asynchronous, active-high reset
//   ready1          in   1       IF can accept PC1 this cycle
//   redirect_valid  in   1       one-cycle redirect request from EX/WB
//   redirect_pc     in   ADDR_W  redirect target (low two bits truncated)
//   halt_req        in   1       stop fetching (sticky until reset)
//   valid1          out  1       PC1 is a valid fetch request
//   PC1             out  ADDR_W  fetch PC presented to IF
//   misalign        out  1       pulse: the previous redirect had pc[1:0]!=0
//   halted          out  1       block is in HALT
//
// Optional feature (macro YSYX_22041071_PCGEN_PERF_EN)
//   When defined, three saturating 64-bit counters are added as outputs:
//   perf_issue (handshakes), perf_stall (RUN cycles with valid1&!ready1) and
//   perf_redir (redirects taken in RUN). When undefined, the ports and the
//   counter logic are absent and the functional behaviour is unchanged.
// ----------------------------------------------------------------------------
module ysyx_22041071_pc_gen #(
  parameter int                ADDR_W     = 64,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(64'h8000_0000),
  parameter int                INST_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready1,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic              valid1,
  output logic [ADDR_W-1:0] PC1,
  output logic              misalign,
  output logic              halted
`ifdef YSYX_22041071_PCGEN_PERF_EN
  ,
  output logic [63:0]       perf_issue,
  output logic [63:0]       perf_stall,
  output logic [63:0]       perf_redir
`endif
);

  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(INST_BYTES);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              r_misalign;
  logic              w_misalign_nxt;
  logic              w_run;
  logic              w_handshake;
  logic              w_redir_take;

  assign w_run        = (r_state == S_RUN);
  assign w_handshake  = w_run & ready1;
  // A halt in the same cycle pre-empts the redirect.
  assign w_redir_take = w_run & !halt_req & redirect_valid;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: BOOT lasts exactly one cycle; HALT is terminal.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_BOOT:  w_state_nxt = S_RUN;
      S_RUN:   if (halt_req) w_state_nxt = S_HALT;
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_BOOT;
    endcase
  end

  // Outputs decoded from state so async reset reaches them without a clock.
  always_comb begin
    valid1 = 1'b0;
    halted = 1'b0;
    unique case (r_state)
      S_RUN:   valid1 = 1'b1;
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  // PC update: halt > redirect > handshake. A redirect flushes the current
  // request whether or not it was accepted, so it overrides the increment.
  always_comb begin
    w_pc_nxt       = r_pc;
    w_misalign_nxt = 1'b0;
    if (w_run && !halt_req) begin
      if (redirect_valid) begin
        w_pc_nxt       = {redirect_pc[ADDR_W-1:2], 2'b00};
        w_misalign_nxt = |redirect_pc[1:0];
      end else if (ready1) begin
        w_pc_nxt = r_pc + PC_INC;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= START_ADDR;
      r_misalign <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  assign PC1      = r_pc;
  assign misalign = r_misalign;

`ifdef YSYX_22041071_PCGEN_PERF_EN
  function automatic logic [63:0] sat_inc(input logic [63:0] v);
    return (&v) ? v : v + 64'd1;
  endfunction

  logic [63:0] r_perf_issue;
  logic [63:0] r_perf_stall;
  logic [63:0] r_perf_redir;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_issue <= '0;
      r_perf_stall <= '0;
      r_perf_redir <= '0;
    end else begin
      if (w_handshake)          r_perf_issue <= sat_inc(r_perf_issue);
      if (w_run && !ready1)     r_perf_stall <= sat_inc(r_perf_stall);
      if (w_redir_take)         r_perf_redir <= sat_inc(r_perf_redir);
    end
  end

  assign perf_issue = r_perf_issue;
  assign perf_stall = r_perf_stall;
  assign perf_redir = r_perf_redir;
`else
  logic w_unused_perf;
  assign w_unused_perf = w_handshake | w_redir_take;
`endif

endmodule

// File: tb/tb_ysyx_22041071_pc_gen.sv
module tb_ysyx_22041071_pc_gen;

  localparam logic [63:0] START = 64'h8000_0000;

  logic        clk;
  logic        reset;
  logic        ready1;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt_req;
  logic        valid1;
  logic [63:0] PC1;
  logic        misalign;
  logic        halted;
`ifdef YSYX_22041071_PCGEN_PERF_EN
  logic [63:0] perf_issue, perf_stall, perf_redir;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: counts cycles since reset release, a sticky halt flag,
  // the PC value and the misalign pulse.
  int          m_cyc;
  bit          m_halt;
  logic [63:0] m_pc;
  bit          m_mis;
`ifdef YSYX_22041071_PCGEN_PERF_EN
  logic [63:0] m_issue, m_stall, m_redir;
`endif

  ysyx_22041071_pc_gen dut (
    .clk            (clk),
    .reset          (reset),
    .ready1         (ready1),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .valid1         (valid1),
    .PC1            (PC1),
    .misalign       (misalign),
    .halted         (halted)
`ifdef YSYX_22041071_PCGEN_PERF_EN
    ,
    .perf_issue     (perf_issue),
    .perf_stall     (perf_stall),
    .perf_redir     (perf_redir)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit m_valid();
    return (m_cyc >= 1) && !m_halt;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".valid1"},   {63'd0, valid1},   {63'd0, m_valid()});
    chk({tag, ".PC1"},      PC1,               m_pc);
    chk({tag, ".misalign"}, {63'd0, misalign}, {63'd0, m_mis});
    chk({tag, ".halted"},   {63'd0, halted},   {63'd0, m_halt});
`ifdef YSYX_22041071_PCGEN_PERF_EN
    chk({tag, ".perf_issue"}, perf_issue, m_issue);
    chk({tag, ".perf_stall"}, perf_stall, m_stall);
    chk({tag, ".perf_redir"}, perf_redir, m_redir);
`endif
  endtask

  task automatic model_reset();
    m_cyc  = 0;
    m_halt = 0;
    m_pc   = START;
    m_mis  = 0;
`ifdef YSYX_22041071_PCGEN_PERF_EN
    m_issue = 0; m_stall = 0; m_redir = 0;
`endif
  endtask

  // Apply inputs for one cycle, advance the model across the clock edge,
  // then compare just after the edge.
  task automatic step(input string tag, input bit rdy, input bit rv,
                      input logic [63:0] rpc, input bit hr);
    bit v;
    ready1         = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt_req       = hr;
    @(posedge clk);
    v     = m_valid();
    m_mis = 0;
`ifdef YSYX_22041071_PCGEN_PERF_EN
    if (v && rdy)         m_issue = m_issue + 1;
    if (v && !rdy)        m_stall = m_stall + 1;
    if (v && !hr && rv)   m_redir = m_redir + 1;
`endif
    if (v) begin
      if (hr) m_halt = 1;
      else if (rv) begin
        m_pc  = rpc - 64'(rpc % 4);
        m_mis = (rpc % 4) != 0;
      end else if (rdy) m_pc = m_pc + 64'd4;
    end
    if (m_cyc < 2) m_cyc++;
    #1;
    chk_all(tag);
  endtask

  // Assert reset mid-cycle, check the asynchronous effect before any edge,
  // then release away from the clock edge.
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk_all({tag, ".async"});
    #2;
    reset = 1'b0;
    #1;
    chk_all({tag, ".cyc0"});
  endtask

  initial begin
    reset = 1'b1; ready1 = 0; redirect_valid = 0; redirect_pc = 0; halt_req = 0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset("t1.reset");

    // 1: boot then three handshakes
    step("t1.boot", 1, 0, 0, 0);
    chk("t1.valid_after_boot", {63'd0, valid1}, 64'd1);
    step("t1.hs1", 1, 0, 0, 0);
    step("t1.hs2", 1, 0, 0, 0);
    chk("t1.pc8", PC1, 64'h8000_0008);
    // 2: five stall cycles at 0x8000_0008
    for (int i = 0; i < 5; i++) step("t2.stall", 0, 0, 0, 0);
    chk("t2.pc_stable", PC1, 64'h8000_0008);
    step("t1.hs3", 1, 0, 0, 0);
    chk("t1.pcC", PC1, 64'h8000_000C);

    // 3: misaligned redirect while stalled
    step("t3.redir", 0, 1, 64'h8000_1002, 0);
    chk("t3.pc", PC1, 64'h8000_1000);
    chk("t3.mis", {63'd0, misalign}, 64'd1);
    step("t3.after", 0, 0, 0, 0);
    chk("t3.mis_clear", {63'd0, misalign}, 64'd0);

    // 4: halt and redirect together; later redirects ignored
    step("t4.halt", 1, 1, 64'h1234_5678, 1);
    chk("t4.halted", {63'd0, halted}, 64'd1);
    chk("t4.pc", PC1, 64'h8000_1000);
    for (int i = 0; i < 3; i++) step("t4.ignored", 1, 1, 64'h9000_0000, 0);

    // 5: wrap around the top of the address space
    do_reset("t5.reset");
    step("t5.boot", 1, 0, 0, 0);
    step("t5.redir", 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    step("t5.wrap", 1, 0, 0, 0);
    chk("t5.pc0", PC1, 64'd0);

    // 6: async reset mid-run at 0x8000_0040
    step("t6.redir", 0, 1, 64'h8000_0040, 0);
    step("t6.hold", 0, 0, 0, 0);
    chk("t6.pc40", PC1, 64'h8000_0040);
    do_reset("t6.reset");
    chk("t6.pc_reset", PC1, START);
    step("t6.boot", 1, 1, 64'h4444_0000, 1);  // ignored in BOOT

    // Randomised traffic against the model with occasional resets
    for (int i = 0; i < 400; i++) begin
      bit rdy, rv, hr;
      logic [63:0] rpc;
      if (i % 80 == 79) do_reset("rnd.reset");
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 9) == 0);
      hr  = ($urandom_range(0, 149) == 0);
      rpc = {$urandom, $urandom};
      step("rnd", rdy, rv, rpc, hr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
